// File: rtl/lagged_sum_seq_gen.sv
// lagged_sum_seq_gen
// Streams the lagged-sum sequence a(n) = a(n-1) + a(n-L) over a
// valid/ready interface, with the lag L chosen at run time.
// Seeds for lag L: a(0)=0, a(1..L-2)=1, a(L-1)=2.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start           load seeds with lag_in/mode_in and begin streaming
//   stop            abort to IDLE (priority over start and accept)
//   lag_in          lag L, legal range 3..MAX_LAG, sampled on start
//   mode_in         overflow policy, sampled on start: 0 restart, 1 halt
//   out_ready       downstream accepts the current term
//   out_valid       out_data/out_index hold a valid term
//   out_data        current term a(n)
//   out_index       n modulo 2^IDX_W
//   busy            high while streaming
//   wrap            one-cycle pulse on an overflow restart
//   overflow        sticky flag set when an overflow halts the stream
//   cfg_err         one-cycle pulse when start carries an illegal lag
module lagged_sum_seq_gen #(
    parameter int WIDTH   = 64,
    parameter int MAX_LAG = 8,
    parameter int IDX_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic [$clog2(MAX_LAG+1)-1:0] lag_in,
    input  logic                         mode_in,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [IDX_W-1:0]             out_index,
    output logic                         busy,
    output logic                         wrap,
    output logic                         overflow,
    output logic                         cfg_err
);

    localparam int LAG_W = $clog2(MAX_LAG + 1);
    localparam int AW    = $clog2(MAX_LAG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   win_r [0:MAX_LAG-1];
    logic [WIDTH-1:0]   win_s [0:MAX_LAG-1];
    logic [LAG_W-1:0]   lag_r, lag_s;
    logic               mode_r, mode_s;
    logic [IDX_W-1:0]   index_r, index_s;
    logic               valid_r, valid_s;
    logic               busy_r, busy_s;
    logic               wrap_r, wrap_s;
    logic               overflow_r, overflow_s;
    logic               cfg_err_r, cfg_err_s;
    logic               lag_ok_s;
    logic               accept_s;
    logic [AW-1:0]      top_s;
    logic [WIDTH:0]     sum_s;
    logic               carry_s;

    // Seed value of window slot i for lag `lag`; slots at or above the lag are held at zero.
    function automatic logic [WIDTH-1:0] seed_val(input logic [LAG_W-1:0] lag, input int i);
        int l;
        l = int'(lag);
        if (i == 0) begin
            return {WIDTH{1'b0}};
        end else if (i < l - 1) begin
            return WIDTH'(2'd1);
        end else if (i == l - 1) begin
            return WIDTH'(2'd2);
        end else begin
            return {WIDTH{1'b0}};
        end
    endfunction

    assign lag_ok_s = (lag_in >= LAG_W'(3)) && (lag_in <= LAG_W'(MAX_LAG));
    assign accept_s = valid_r & out_ready;
    // Newest window slot is w[L-1]; the next term is w[L-1] + w[0] with one extra bit for carry.
    assign top_s    = AW'(lag_r - LAG_W'(1));
    assign sum_s    = {1'b0, win_r[top_s]} + {1'b0, win_r[0]};
    assign carry_s  = sum_s[WIDTH];

    // Next-state, window and flag computation.
    always_comb begin
        state_s    = state_r;
        lag_s      = lag_r;
        mode_s     = mode_r;
        index_s    = index_r;
        overflow_s = overflow_r;
        wrap_s     = 1'b0;
        cfg_err_s  = 1'b0;
        for (int i = 0; i < MAX_LAG; i++) begin
            win_s[i] = win_r[i];
        end

        if (stop) begin
            state_s = ST_IDLE;
        end else if (start && lag_ok_s) begin
            // A legal start restarts from any state; a pending term is dropped.
            for (int i = 0; i < MAX_LAG; i++) begin
                win_s[i] = seed_val(lag_in, i);
            end
            lag_s      = lag_in;
            mode_s     = mode_in;
            index_s    = {IDX_W{1'b0}};
            overflow_s = 1'b0;
            state_s    = ST_RUN;
        end else if (start) begin
            cfg_err_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (accept_s && !carry_s) begin
                        for (int i = 0; i < MAX_LAG; i++) begin
                            if (i < int'(lag_r) - 1) begin
                                win_s[i] = win_r[(i + 1) % MAX_LAG];
                            end else if (i == int'(lag_r) - 1) begin
                                win_s[i] = sum_s[WIDTH-1:0];
                            end else begin
                                win_s[i] = {WIDTH{1'b0}};
                            end
                        end
                        index_s = index_r + IDX_W'(1);
                    end else if (accept_s && !mode_r) begin
                        for (int i = 0; i < MAX_LAG; i++) begin
                            win_s[i] = seed_val(lag_r, i);
                        end
                        index_s = {IDX_W{1'b0}};
                        wrap_s  = 1'b1;
                    end else if (accept_s) begin
                        // Window is left alone so out_data keeps the accepted term.
                        state_s    = ST_HALT;
                        overflow_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end

        valid_s = (state_s == ST_RUN);
        busy_s  = (state_s == ST_RUN);
    end

    // State, window and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lag_r      <= LAG_W'(3);
            mode_r     <= 1'b0;
            index_r    <= {IDX_W{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            wrap_r     <= 1'b0;
            overflow_r <= 1'b0;
            cfg_err_r  <= 1'b0;
            for (int i = 0; i < MAX_LAG; i++) begin
                win_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r    <= state_s;
            lag_r      <= lag_s;
            mode_r     <= mode_s;
            index_r    <= index_s;
            valid_r    <= valid_s;
            busy_r     <= busy_s;
            wrap_r     <= wrap_s;
            overflow_r <= overflow_s;
            cfg_err_r  <= cfg_err_s;
            for (int i = 0; i < MAX_LAG; i++) begin
                win_r[i] <= win_s[i];
            end
        end
    end

    assign out_valid = valid_r;
    assign out_data  = win_r[0];
    assign out_index = index_r;
    assign busy      = busy_r;
    assign wrap      = wrap_r;
    assign overflow  = overflow_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_lagged_sum_seq_gen.sv
// Bench for lagged_sum_seq_gen: an 8-bit instance checked every cycle
// against a recurrence-based reference model, and a 64-bit instance with
// a 4-bit index checked against the literal L=5 stream.
module tb_lagged_sum_seq_gen;

    localparam int ML = 8;
    localparam int LW = $clog2(ML + 1);

    logic clk = 1'b0;
    logic reset, start, stop, mode_in, out_ready;
    logic [LW-1:0] lag_in;

    logic        v8, busy8, wrap8, ovf8, cerr8;
    logic [7:0]  d8;
    logic [15:0] i8;
    logic        v64, busy64, wrap64, ovf64, cerr64;
    logic [63:0] d64;
    logic [3:0]  i64;

    lagged_sum_seq_gen #(.WIDTH(8), .MAX_LAG(ML), .IDX_W(16)) dut8 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lag_in(lag_in),
        .mode_in(mode_in), .out_ready(out_ready), .out_valid(v8), .out_data(d8),
        .out_index(i8), .busy(busy8), .wrap(wrap8), .overflow(ovf8), .cfg_err(cerr8));

    lagged_sum_seq_gen #(.WIDTH(64), .MAX_LAG(ML), .IDX_W(4)) dut64 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lag_in(lag_in),
        .mode_in(mode_in), .out_ready(out_ready), .out_valid(v64), .out_data(d64),
        .out_index(i64), .busy(busy64), .wrap(wrap64), .overflow(ovf64), .cfg_err(cerr64));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (for the 8-bit instance)
    int     m_L = 3;
    bit     m_mode, m_run, m_halt, m_ovf, m_wrap, m_cerr;
    int     m_n;
    longint m_data;
    // 64-bit instance: accepted-term count and literal expected stream
    bit     sec64 = 1'b0;
    int     k64 = 0;
    longint exp64 [0:21] = '{0,1,1,1,2,2,3,4,5,7,9,12,16,21,28,37,49,65,86,114,151,200};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // a(k) for lag L by plain recurrence in unbounded (64-bit) arithmetic
    function automatic longint term(input int L, input int k);
        longint a [0:63];
        for (int j = 0; j <= k && j < 64; j++) begin
            if (j == 0) a[j] = 0;
            else if (j < L - 1) a[j] = 1;
            else if (j == L - 1) a[j] = 2;
            else a[j] = a[j-1] + a[j-L];
        end
        return a[k];
    endfunction

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_ovf = 0; m_wrap = 0; m_cerr = 0;
        m_n = 0; m_data = 0;
    endtask

    // apply one clock edge's worth of behaviour using the inputs seen at that edge
    task automatic model_step();
        m_wrap = 0;
        m_cerr = 0;
        if (stop) begin
            m_run = 0;
            m_halt = 0;
        end else if (start) begin
            if (lag_in < 3 || lag_in > ML) begin
                m_cerr = 1;
            end else begin
                m_L = int'(lag_in); m_mode = mode_in; m_n = 0;
                m_run = 1; m_halt = 0; m_ovf = 0; k64 = 0;
            end
        end else if (m_run && out_ready) begin
            k64++;
            // accepting a(n) produces a(n+L); it must fit in 8 bits
            if (term(m_L, m_n + m_L) >= 256) begin
                if (!m_mode) begin
                    m_n = 0; m_wrap = 1;
                end else begin
                    m_run = 0; m_halt = 1; m_ovf = 1;
                end
            end else begin
                m_n++;
            end
        end
        if (m_run) m_data = term(m_L, m_n);
    endtask

    task automatic check8();
        chk("valid", v8, m_run);
        chk("busy", busy8, m_run);
        chk("wrap", wrap8, m_wrap);
        chk("cfg_err", cerr8, m_cerr);
        chk("overflow", ovf8, m_ovf);
        if (m_run || m_halt) chk("data", d8, m_data);
        if (m_run) chk("index", i8, m_n % 65536);
    endtask

    task automatic check64();
        if (k64 < 22) begin
            chk("valid64", v64, 1);
            chk("data64", d64, exp64[k64]);
            chk("index64", i64, k64 % 16);
            chk("wrap64", wrap64, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check8();
        if (sec64) check64();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, v8, 0);     chk({tag, "_data"}, d8, 0);
        chk({tag, "_index"}, i8, 0);     chk({tag, "_busy"}, busy8, 0);
        chk({tag, "_wrap"}, wrap8, 0);   chk({tag, "_ovf"}, ovf8, 0);
        chk({tag, "_cerr"}, cerr8, 0);   chk({tag, "_valid64"}, v64, 0);
        chk({tag, "_data64"}, d64, 0);   chk({tag, "_index64"}, i64, 0);
        chk({tag, "_busy64"}, busy64, 0); chk({tag, "_ovf64"}, ovf64, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; lag_in = '0;
        mode_in = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // L=3, mode 1, full throughput: stream up to 101, then halt
        start = 1'b1; lag_in = 4'd3; mode_in = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("first_term_latency", v8, 1);
        repeat (18) tick();
        chk("halt_overflow", ovf8, 1);
        chk("halt_data", d8, 101);
        chk("halt_busy", busy8, 0);

        // restart from HALT with mode 0: overflow clears, stream wraps after 101
        start = 1'b1; lag_in = 4'd3; mode_in = 1'b0;
        tick();
        start = 1'b0;
        repeat (22) tick();

        // random backpressure on the 8-bit stream
        for (int c = 0; c < 40; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // illegal lags are ignored with a cfg_err pulse
        out_ready = 1'b0;
        start = 1'b1; lag_in = 4'd2; mode_in = 1'b1;
        tick();
        lag_in = 4'(ML + 1);
        tick();
        start = 1'b0;
        tick();
        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1; lag_in = 4'd4;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (3) tick();

        // L=5 with random backpressure on both instances
        sec64 = 1'b1;
        start = 1'b1; lag_in = 4'd5; mode_in = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300 && k64 < 22; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("stream64_len", (k64 >= 22), 1);
        sec64 = 1'b0;

        // asynchronous reset mid-stream while stalled
        start = 1'b1; lag_in = 4'd3; mode_in = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        out_ready = 1'b0;
        tick();
        chk("stall_valid", v8, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("no_term_after_reset64", v64, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lagged_sum_seq_gen.md
Name: lagged_sum_seq_gen

Overview:
- Parametrised generator for the lagged-sum integer sequence a(n) = a(n-1) + a(n-L), with run-time lag L.
- Streams terms over a valid/ready interface to downstream arithmetic and test blocks.
- Successor to the fixed 5-term, 64-bit, free-running generator. Adds configurable width, lag, backpressure, term indexing and selectable overflow policy (restart or halt).

Parameters:
- WIDTH, 64, bit width of each term and of the internal window registers.
- MAX_LAG, 8, maximum supported lag L; window depth is MAX_LAG (must be >= 3).
- IDX_W, 16, width of out_index.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to (re)start the sequence with lag_in and mode_in.
- stop  input  1  abort the run; return to IDLE.
- lag_in  input  $clog2(MAX_LAG+1)  lag L, sampled on start; legal range 3..MAX_LAG.
- mode_in  input  1  overflow policy, sampled on start: 0 = restart from seeds, 1 = halt.
- out_ready  input  1  downstream accepts the current term.
- out_valid  output  1  out_data/out_index hold a valid term.
- out_data  output  WIDTH  current term a(n).
- out_index  output  IDX_W  n, modulo 2^IDX_W.
- busy  output  1  high in RUN.
- wrap  output  1  one-cycle pulse when a mode-0 restart occurs.
- overflow  output  1  sticky; set on mode-1 halt.
- cfg_err  output  1  one-cycle pulse when start is given with an illegal lag.

Behaviour:
- Reset: state=IDLE. out_valid=0, out_data=0, out_index=0, busy=0, wrap=0, overflow=0, cfg_err=0. All window registers are 0.
- Seeds for lag L:
  - a(0)=0.
  - a(1..L-2)=1.
  - a(L-1)=2.
  - For L=5 this gives 0,1,1,1,2,2,3,4,5,7,9,12,...
- Window: registers w[0..L-1] hold a(n)..a(n+L-1). out_data is w[0].
- Acceptance (accept = out_valid & out_ready), in one cycle:
  - Shift w[i] <= w[i+1] for i < L-1.
  - w[L-1] <= w[L-1] + w[0], computed at WIDTH+1 bits.
  - out_index increments.
  - Registers above L-1 are don't-care and are held at 0.
- Backpressure: while out_valid & !out_ready, out_data and out_index hold stable.
- States:
  - IDLE: out_valid=0.
    - start with legal lag: load seeds, latch L and mode, out_index=0, go to RUN.
    - out_valid=1 with a(0)=0 on the cycle after start (latency 1).
  - RUN: out_valid=1, busy=1.
    - accept with no carry: shift.
    - accept with carry out of WIDTH, mode 0: reload seeds, out_index=0, pulse wrap. Next term is 0.
    - accept with carry out of WIDTH, mode 1: go to HALT, overflow=1, out_valid=0. out_data keeps the accepted term.
  - HALT: out_valid=0, busy=0. start (legal) clears overflow, reloads seeds, goes to RUN.
- Illegal lag: start with lag_in < 3 or lag_in > MAX_LAG is ignored. cfg_err pulses; state, outputs and the latched configuration are unchanged.
- start while in RUN with a legal lag: immediate restart with the new configuration, even if a term is pending. The pending term is dropped.
- stop has priority over start and accept in the same cycle. Any state goes to IDLE; out_valid=0; overflow is preserved.
- out_index wraps modulo 2^IDX_W; the wrap is silent.
- reset mid-run: immediate return to reset values, regardless of handshake state.

Test Plan:
- L=3, WIDTH=8, out_ready=1: start -> terms 0,1,2,2,3,5,7,10,15,22,32,47,69,101 with out_index 0..13; the first term appears 1 cycle after start.
- Same setup, mode 0: accepting 101 (generated sum 318 > 255) -> wrap pulses 1 cycle; next term is 0 with out_index=0; sequence repeats.
- Same setup, mode 1: accepting 101 -> overflow=1, out_valid=0, busy=0. A later start with L=3 -> overflow clears; 0,1,2,... resumes.
- L=5, WIDTH=64, out_ready toggled randomly: stream equals 0,1,1,1,2,2,3,4,5,7,9,12,16,21,28,37,49,65,86,114,151,200. out_data is stable during every stall cycle.
- start with lag_in=2 and, separately, lag_in=MAX_LAG+1 -> cfg_err pulse, state unchanged. start and stop in the same cycle -> IDLE.
- Assert reset mid-stream while out_valid=1, out_ready=0 -> all outputs return to 0 asynchronously; no term is emitted until the next start.
